// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/S/C(+I) access, trap entry, MRET, and the
// optional cycle/instret counters built when CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_funct3,
  input  logic [31:0] csr_rs1,
  input  logic [4:0]  csr_src_idx,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mscratch_q, mcause_q, mtval_q;
  logic [29:0] mtvec_q, mepc_q;

  logic        known;
  logic [31:0] old_val, operand, new_val;
  logic        wr_req, wr_ok;
  logic        unused_in;

`ifdef CSR_COUNTERS_EN
  logic [CNT_WIDTH-1:0] mcycle_q, minstret_q;
  logic [31:0]          mcycle_hi, minstret_hi;

  always_comb begin
    mcycle_hi                  = '0;
    minstret_hi                = '0;
    mcycle_hi[CNT_WIDTH-33:0]   = mcycle_q[CNT_WIDTH-1:32];
    minstret_hi[CNT_WIDTH-33:0] = minstret_q[CNT_WIDTH-1:32];
  end

  assign unused_in = ^trap_pc[1:0];
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
  assign unused_in  = ^{trap_pc[1:0], instret};
`endif

  always_comb begin
    known   = 1'b1;
    old_val = '0;
    case (csr_addr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      12'h304: old_val = mie_q;
      12'h305: old_val = {mtvec_q, 2'b00};
      12'h340: old_val = mscratch_q;
      12'h341: old_val = {mepc_q, 2'b00};
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: old_val = mcycle_q[31:0];
      12'hB80, 12'hC80: old_val = mcycle_hi;
      12'hB02, 12'hC02: old_val = minstret_q[31:0];
      12'hB82, 12'hC82: old_val = minstret_hi;
`endif
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    operand = csr_funct3[2] ? {27'b0, csr_src_idx} : csr_rs1;
    case (csr_funct3[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

  // Set/clear forms with a zero source are pure reads, so they may target read-only CSRs.
  assign wr_req      = csr_valid & ((csr_funct3[1:0] == 2'b01) | (csr_src_idx != 5'd0));
  assign csr_illegal = csr_valid & (~known | (csr_funct3[1:0] == 2'b00) |
                                    ((csr_addr[11:10] == 2'b11) & wr_req));
  assign wr_ok       = wr_req & ~csr_illegal & ~trap_valid;
  assign csr_rdata   = (csr_valid & known) ? old_val : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap_valid) begin
      mepc_q   <= trap_pc[31:2];
      mcause_q <= trap_cause;
      mtval_q  <= trap_tval;
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else begin
      if (mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_ok && csr_addr == 12'h300) begin
        mst_mie  <= new_val[3];
        mst_mpie <= new_val[7];
      end
      if (wr_ok) begin
        case (csr_addr)
          12'h304: mie_q      <= new_val;
          12'h305: mtvec_q    <= new_val[31:2];
          12'h340: mscratch_q <= new_val;
          12'h341: mepc_q     <= new_val[31:2];
          12'h342: mcause_q   <= new_val;
          12'h343: mtval_q    <= new_val;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write replaces the whole counter from the pre-increment value: no carry, increment lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= mcycle_q + CNT_WIDTH'(1);
      if (instret) minstret_q <= minstret_q + CNT_WIDTH'(1);
      if (wr_ok) begin
        case (csr_addr)
          12'hB00: mcycle_q   <= {mcycle_q[CNT_WIDTH-1:32], new_val};
          12'hB80: mcycle_q   <= {new_val[CNT_WIDTH-33:0], mcycle_q[31:0]};
          12'hB02: minstret_q <= {minstret_q[CNT_WIDTH-1:32], new_val};
          12'hB82: minstret_q <= {new_val[CNT_WIDTH-33:0], minstret_q[31:0]};
          default: ;
        endcase
      end
    end
  end
`endif

  assign mtvec_out  = {mtvec_q, 2'b00};
  assign mepc_out   = {mepc_q, 2'b00};
  assign mie_global = mst_mie;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios then randomized traffic checked
// against a behavioural CSR model; follows CSR_COUNTERS_EN like the design.
module tb_csr_file;
  localparam int unsigned CW  = 40;
  localparam logic [31:0] MTV = 32'h0000_2F07;
  localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n, csr_valid, instret, trap_valid, mret;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [31:0] csr_rs1, trap_cause, trap_pc, trap_tval;
  logic [4:0]  csr_src_idx;
  logic [31:0] csr_rdata, mtvec_out, mepc_out;
  logic        csr_illegal, mie_global;

  always #5 clk = ~clk;

  csr_file #(.CNT_WIDTH(CW), .MTVEC_RESET(MTV)) dut (
    .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_addr(csr_addr),
    .csr_funct3(csr_funct3), .csr_rs1(csr_rs1), .csr_src_idx(csr_src_idx),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret(instret),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret(mret), .mtvec_out(mtvec_out),
    .mepc_out(mepc_out), .mie_global(mie_global)
  );

  int unsigned n_cmp = 0, n_bad = 0;

  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  task automatic m_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mie_reg = '0; m_mtvec = MTV & ~32'd3;
    m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
    m_cyc = '0; m_ins = '0;
  endtask

  function automatic void m_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
    ok = 1'b1;
    v  = '0;
    case (a)
      12'h300: v = 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
`endif
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_addr = '0; csr_funct3 = '0; csr_rs1 = '0; csr_src_idx = '0;
    trap_valid = 1'b0; mret = 1'b0; instret = 1'b0;
    #1;
  endtask

  task automatic acc(input logic [11:0] a, input logic [2:0] f, input logic [31:0] r, input logic [4:0] i);
    csr_valid = 1'b1; csr_addr = a; csr_funct3 = f; csr_rs1 = r; csr_src_idx = i;
    #1;
  endtask

  // Check current outputs against the model, clock once, advance the model.
  task automatic cyc();
    logic ok, ill, wants;
    logic [31:0] old, op, nv;
    logic [63:0] c0, i0;
    m_read(csr_addr, ok, old);
    wants = (csr_funct3[1:0] == 2'b01) || (csr_src_idx != 5'd0);
    ill   = csr_valid && (!ok || csr_funct3[1:0] == 2'b00 || (csr_addr[11:10] == 2'b11 && wants));
    chk("illegal", 32'(csr_illegal), 32'(ill));
    if (!(csr_valid && ok && ill)) chk("rdata", csr_rdata, (csr_valid && ok) ? old : 32'd0);
    chk("mtvec_out", mtvec_out, m_mtvec);
    chk("mepc_out", mepc_out, m_mepc);
    chk("mie_global", 32'(mie_global), 32'(m_mie));
    op = csr_funct3[2] ? {27'b0, csr_src_idx} : csr_rs1;
    case (csr_funct3[1:0])
      2'b01:   nv = op;
      2'b10:   nv = old | op;
      2'b11:   nv = old & ~op;
      default: nv = old;
    endcase
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      c0 = m_cyc; i0 = m_ins;
      m_cyc = (m_cyc + 64'd1) & CMASK;
      if (instret) m_ins = (m_ins + 64'd1) & CMASK;
      if (trap_valid) begin
        m_mepc = trap_pc & ~32'd3; m_mcause = trap_cause; m_mtval = trap_tval;
        m_mpie = m_mie; m_mie = 1'b0;
      end else begin
        if (mret) begin m_mie = m_mpie; m_mpie = 1'b1; end
        if (csr_valid && !ill && wants) begin
          case (csr_addr)
            12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_mie_reg = nv;
            12'h305: m_mtvec = nv & ~32'd3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            12'hB00: m_cyc = {c0[63:32], nv};
            12'hB80: m_cyc = ({nv, 32'd0} | {32'd0, c0[31:0]}) & CMASK;
            12'hB02: m_ins = {i0[63:32], nv};
            12'hB82: m_ins = ({nv, 32'd0} | {32'd0, i0[31:0]}) & CMASK;
            default: ;
          endcase
        end
      end
    end
    @(negedge clk);
  endtask

  logic [11:0] alist [17] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                              12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h301};

  initial begin
    m_reset();
    rst_n = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Access in flight during reset is discarded.
    acc(12'h340, 3'b001, 32'h1234_5678, 5'd1);
    cyc();
    rst_n = 1'b1;
    idle();
    chk("rst_mtvec", mtvec_out, 32'h0000_2F04);
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_mie", 32'(mie_global), 32'd0);

    acc(12'h340, 3'b001, 32'hDEAD_BEEF, 5'd7);
    chk("csrrw_old", csr_rdata, 32'd0);
    cyc();
    acc(12'h340, 3'b010, 32'hFFFF_FFFF, 5'd0);
    chk("csrrs_read", csr_rdata, 32'hDEAD_BEEF);
    cyc();

    acc(12'h300, 3'b110, 32'd0, 5'd8);
    cyc();
    idle();
    chk("mie_set", 32'(mie_global), 32'd1);
    trap_valid = 1'b1; trap_pc = 32'h0000_1236; trap_cause = 32'd2; trap_tval = 32'h55;
    cyc();
    idle();
    chk("trap_mepc", mepc_out, 32'h0000_1234);
    acc(12'h342, 3'b010, 32'd0, 5'd0);
    chk("trap_mcause", csr_rdata, 32'd2);
    cyc();
    acc(12'h300, 3'b010, 32'd0, 5'd0);
    chk("trap_mstatus", csr_rdata, 32'h0000_1880);
    cyc();
    idle(); mret = 1'b1;
    cyc();
    idle();
    chk("mret_mie", 32'(mie_global), 32'd1);

    acc(12'h305, 3'b001, 32'hFFFF_FF00, 5'd1);
    trap_valid = 1'b1; trap_pc = 32'h0000_0088;
    cyc();
    idle();
    chk("trap_drop_mtvec", mtvec_out, 32'h0000_2F04);
    chk("trap_mepc2", mepc_out, 32'h0000_0088);
    acc(12'h300, 3'b111, 32'd0, 5'd8); mret = 1'b1;
    cyc();
    idle();
    chk("mret_wins", 32'(mie_global), 32'd1);

    acc(12'hC00, 3'b001, 32'h123, 5'd0);
    chk("ro_write_ill", 32'(csr_illegal), 32'd1);
    cyc();
    acc(12'hC00, 3'b010, 32'd0, 5'd0);
`ifdef CSR_COUNTERS_EN
    chk("ro_read_legal", 32'(csr_illegal), 32'd0);
`else
    chk("ro_read_unknown", 32'(csr_illegal), 32'd1);
`endif
    cyc();
    acc(12'h7C0, 3'b010, 32'd0, 5'd0);
    chk("unknown_ill", 32'(csr_illegal), 32'd1);
    cyc();
    acc(12'h340, 3'b100, 32'd0, 5'd3);
    chk("f3_100_ill", 32'(csr_illegal), 32'd1);
    cyc();
    acc(12'h340, 3'b010, 32'd0, 5'd0);
    chk("scratch_kept", csr_rdata, 32'hDEAD_BEEF);
    cyc();

`ifdef CSR_COUNTERS_EN
    acc(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0);
    cyc();
    acc(12'hB00, 3'b010, 32'd0, 5'd0);
    chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
    cyc();
    acc(12'hB80, 3'b010, 32'd0, 5'd0);
    chk("mcycleh_carry", csr_rdata, 32'd1);
    cyc();
    acc(12'hB02, 3'b001, 32'd0, 5'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle(); instret = (i != 1);
      cyc();
    end
    acc(12'hB02, 3'b010, 32'd0, 5'd0);
    chk("minstret_count", csr_rdata, 32'd3);
    cyc();
`else
    acc(12'hB00, 3'b010, 32'd0, 5'd0);
    chk("nocnt_ill", 32'(csr_illegal), 32'd1);
    chk("nocnt_rdata", csr_rdata, 32'd0);
    cyc();
`endif

    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(99) >= 2);
      csr_valid   = ($urandom_range(9) < 8);
      csr_addr    = alist[$urandom_range(16)];
      csr_funct3  = 3'($urandom);
      csr_rs1     = $urandom;
      csr_src_idx = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      trap_valid  = ($urandom_range(9) == 0);
      mret        = ($urandom_range(9) == 0);
      instret     = 1'($urandom);
      trap_pc     = $urandom; trap_cause = $urandom; trap_tval = $urandom;
      #1;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the pipelined RV32 core, replacing the combinational CSR operation unit with a stateful block that holds the CSRs. It sits beside the register file in the execute stage:
- executes CSRRW/CSRRS/CSRRC and their immediate forms against internal registers;
- returns the old CSR value for rd;
- flags illegal accesses;
- performs trap entry and MRET state updates;
- optionally maintains 64-bit cycle/instret counters.

## Interface

Parameters:
- CNT_WIDTH, 64: counter width, legal range 33..64.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec. Bits [1:0] are ignored.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- csr_valid  input  1  CSR instruction executing this cycle
- csr_addr  input  12  CSR address
- csr_funct3  input  3  instruction funct3
- csr_rs1  input  32  rs1 value (register forms)
- csr_src_idx  input  5  rs1 index (register forms) or zimm (immediate forms)
- csr_rdata  output  32  pre-update CSR value, written to rd
- csr_illegal  output  1  access is illegal this cycle
- instret  input  1  one instruction retires this cycle
- trap_valid  input  1  take trap this cycle
- trap_cause  input  32  value for mcause
- trap_pc  input  32  faulting PC
- trap_tval  input  32  value for mtval
- mret  input  1  MRET executing this cycle
- mtvec_out  output  32  current mtvec
- mepc_out  output  32  current mepc
- mie_global  output  1  mstatus.MIE

## Operation

Implemented CSRs:

| Name | Address | Stored bits | Read behaviour |
|---|---|---|---|
| mstatus | 0x300 | MIE[3], MPIE[7] | MPP[12:11] reads 2'b11; all other bits read 0 |
| mie | 0x304 | full 32 bits | stored value |
| mtvec | 0x305 | [31:2] | [1:0] read 0 |
| mscratch | 0x340 | full 32 bits | stored value |
| mepc | 0x341 | [31:2] | [1:0] read 0 |
| mcause | 0x342 | full 32 bits | stored value |
| mtval | 0x343 | full 32 bits | stored value |

Counters, present only with the macro (see Configuration):
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- Read-only shadows: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- The *h registers read counter bits [CNT_WIDTH-1:32], zero-extended to 32 bits.

Operand selection:
- funct3 001/010/011: operand is csr_rs1.
- funct3 101/110/111: operand is {27'b0, csr_src_idx}.

New value by funct3:
- 001/101: operand.
- 010/110: old | operand.
- 011/111: old & ~operand.

Write enable:
- funct3 001/101: always write.
- Set/clear forms: write only when csr_src_idx != 0.
- A read-only CSR accessed without a write is legal.

csr_illegal = csr_valid & (unknown address | funct3 ∈ {000, 100} | write to csr_addr[11:10]==2'b11). When csr_illegal is high, no CSR state changes from the access.

Trap entry (trap_valid):
- mepc <= {trap_pc[31:2], 2'b00}; mcause <= trap_cause; mtval <= trap_tval.
- MPIE <= MIE; MIE <= 0.

MRET (mret):
- MIE <= MPIE; MPIE <= 1.

Counters:
- mcycle increments by 1 every cycle out of reset.
- minstret increments by 1 when instret is high.
- Both wrap modulo 2^CNT_WIDTH.
- Writing the low half replaces bits [31:0]; writing the high half replaces bits [CNT_WIDTH-1:32] with the low CNT_WIDTH-32 operand bits.

## Timing

- csr_rdata and csr_illegal are combinational from current state and inputs, so rdata is valid in the same cycle. When csr_valid=0, csr_rdata is 0.
- All state updates occur on the rising clk edge. The new value is visible to an access in the next cycle.
- Reset (rst_n=0 at an edge) has priority over everything. Reset values:
  - all CSRs 0, except mtvec = {MTVEC_RESET[31:2], 2'b00};
  - counters 0;
  - mtvec_out = MTVEC_RESET & ~3, mepc_out = 0, mie_global = 0.
- Reset asserted while an access is in flight discards the access.
- Update priority per edge: trap_valid > mret > CSR write.
  - trap_valid with a CSR write in the same cycle: the write is dropped and trap updates apply.
  - mret with a write to mstatus: the mret update wins. Writes to other CSRs in that cycle still apply.
- Counter write in the same cycle as an increment: the written value is stored and the increment is lost for that cycle. Writing the low half leaves the high half unchanged; there is no carry from the write.
- Outputs mtvec_out, mepc_out and mie_global reflect registered state only.

## Configuration

- CSR_COUNTERS_EN defined:
  - mcycle/minstret and their high halves and read-only shadows exist;
  - instret is used.
- CSR_COUNTERS_EN undefined:
  - no counter registers are built;
  - all eight counter addresses are unknown, so csr_illegal=1;
  - instret is ignored;
  - CNT_WIDTH is unused.

## Test plan

- Reset, then CSRRW mscratch with rs1 = 0xDEAD_BEEF → rdata = 0. Next cycle, CSRRS mscratch with src_idx = 0 → rdata = 0xDEAD_BEEF, no write.
- CSRRSI mstatus with zimm = 8 → mie_global = 1 on the next cycle. Then trap_valid with pc = 0x0000_1236, cause = 2 → mepc_out = 0x1234, mcause = 2, MIE = 0, MPIE = 1. Then mret → MIE = 1.
- CSRRW mtvec in the same cycle as trap_valid → mtvec unchanged and trap updates applied. CSRRC mstatus together with mret → mret result only.
- Write to cycle (0xC00) → csr_illegal = 1, no change. CSRRS 0xC00 with src_idx = 0 → legal. Unknown address 0x7C0 → illegal. funct3 100 → illegal.
- With CSR_COUNTERS_EN:
  - CSRRW mcycle = 0xFFFF_FFFF → next-cycle read of mcycle = 0xFFFF_FFFF; the read after that shows mcycleh = 1 and mcycle = 0.
  - minstret increments only on cycles with instret high.
- Without CSR_COUNTERS_EN: read of 0xB00 → csr_illegal = 1 and rdata = 0.
